// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for param_fifo and its storage array:
//   - addr_w(depth)  : pointer width, never narrower than one bit
//   - count_w(depth) : occupancy counter width, wide enough to hold DEPTH
//   - FWFT_STD / FWFT_FALL : read-mode encodings for the FWFT parameter
// -----------------------------------------------------------------------------
package fifo_pkg;

  localparam int FWFT_STD  = 0;  // registered read, 1-cycle RD_VALID pulse
  localparam int FWFT_FALL = 1;  // head word presented combinationally

  function automatic int addr_w(input int depth);
    int w;
    w = $clog2(depth);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int count_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage : fifo_pkg

// File: rtl/fifo_mem.sv
// -----------------------------------------------------------------------------
// fifo_mem
// DEPTH x DATA_W register array with one clocked write port and one
// asynchronous read port. Contents are not reset.
// Ports:
//   clk      in  write clock, rising edge
//   wr_en    in  write enable
//   wr_addr  in  write address
//   wr_data  in  write data
//   rd_addr  in  read address
//   rd_data  out read data (combinational from rd_addr)
// -----------------------------------------------------------------------------
module fifo_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: storage has no reset so it maps onto plain flops/RAM without a
  // reset tree; the pointers and counter guarantee stale words are never read.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule : fifo_mem

// File: rtl/param_fifo.sv
// -----------------------------------------------------------------------------
// param_fifo
// Parametrised single-clock FIFO with standard or first-word-fall-through read
// mode, registered status flags, occupancy count, sticky error flags and a
// synchronous flush.
// Ports:
//   CLK           in  clock, rising edge
//   RST_N         in  asynchronous active-low reset
//   SCLR          in  synchronous flush, has priority over WR_EN/RD_EN
//   DATA_IN       in  write data
//   WR_EN         in  write request
//   RD_EN         in  read request (acknowledge/pop in FWFT mode)
//   DATA_OUT      out read data
//   RD_VALID      out DATA_OUT valid (pulse in standard mode, !EMPTY in FWFT)
//   EMPTY, FULL   out occupancy == 0 / == DEPTH
//   ALMOST_EMPTY  out COUNT <= AE_THRESH
//   ALMOST_FULL   out COUNT >= AF_THRESH
//   COUNT         out occupancy
//   OVERFLOW      out sticky: write attempted while full
//   UNDERFLOW     out sticky: read attempted while empty
// -----------------------------------------------------------------------------
module param_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2,
  parameter int FWFT      = FWFT_STD
) (
  input  logic                        CLK,
  input  logic                        RST_N,
  input  logic                        SCLR,
  input  logic [DATA_W-1:0]           DATA_IN,
  input  logic                        WR_EN,
  input  logic                        RD_EN,
  output logic [DATA_W-1:0]           DATA_OUT,
  output logic                        RD_VALID,
  output logic                        EMPTY,
  output logic                        FULL,
  output logic                        ALMOST_EMPTY,
  output logic                        ALMOST_FULL,
  output logic [count_w(DEPTH)-1:0]   COUNT,
  output logic                        OVERFLOW,
  output logic                        UNDERFLOW
);

  localparam int AW = addr_w(DEPTH);
  localparam int CW = count_w(DEPTH);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C      = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C      = CW'(AE_THRESH);
  localparam logic          AF_RST    = (AF_THRESH == 0);

  // Elaboration-time parameter sanity checks.
  if (DEPTH < 2) begin : g_chk_depth
    $error("param_fifo: DEPTH must be >= 2");
  end
  if (AF_THRESH > DEPTH || AF_THRESH < 0) begin : g_chk_af
    $error("param_fifo: AF_THRESH must be in 0..DEPTH");
  end
  if (AE_THRESH >= DEPTH || AE_THRESH < 0) begin : g_chk_ae
    $error("param_fifo: AE_THRESH must be in 0..DEPTH-1");
  end
  if (FWFT != FWFT_STD && FWFT != FWFT_FALL) begin : g_chk_mode
    $error("param_fifo: FWFT must be 0 or 1");
  end

  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q, count_nxt;
  logic              empty_q, full_q, ae_q, af_q;
  logic              ovf_q, unf_q;
  logic              wr_acc, rd_acc, mem_we;
  logic [DATA_W-1:0] mem_rdata;

  // Explicit wrap so non-power-of-two depths never address past DEPTH-1.
  function automatic logic [AW-1:0] inc_ptr(input logic [AW-1:0] p);
    return (p == LAST_ADDR) ? '0 : p + AW'(1);
  endfunction

  // Acceptance uses only registered flags, so no input reaches an output
  // combinationally.
  // NOTE: every always_comb output gets a default first so no latch is
  // inferred on paths that don't assign it.
  always_comb begin
    wr_acc    = WR_EN && !full_q;
    rd_acc    = RD_EN && !empty_q;
    count_nxt = count_q;
    if (wr_acc && !rd_acc)      count_nxt = count_q + CW'(1);
    else if (rd_acc && !wr_acc) count_nxt = count_q - CW'(1);
  end

  assign mem_we = wr_acc && !SCLR;

  fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (AW)
  ) u_mem (
    .clk     (CLK),
    .wr_en   (mem_we),
    .wr_addr (wr_ptr_q),
    .wr_data (DATA_IN),
    .rd_addr (rd_ptr_q),
    .rd_data (mem_rdata)
  );

  // Pointers, counter and flags. Flags are registered from the next-state
  // count so they line up with COUNT after every edge.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      ae_q     <= 1'b1;
      af_q     <= AF_RST;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else if (SCLR) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      ae_q     <= 1'b1;
      af_q     <= AF_RST;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr_q <= inc_ptr(wr_ptr_q);
      if (rd_acc) rd_ptr_q <= inc_ptr(rd_ptr_q);
      count_q <= count_nxt;
      empty_q <= (count_nxt == '0);
      full_q  <= (count_nxt == DEPTH_C);
      ae_q    <= (count_nxt <= AE_C);
      af_q    <= (count_nxt >= AF_C);
      // Sticky: set on the request itself, even if the other side was accepted.
      if (WR_EN && full_q)  ovf_q <= 1'b1;
      if (RD_EN && empty_q) unf_q <= 1'b1;
    end
  end

  // Read data path.
  if (FWFT == FWFT_FALL) begin : g_fwft
    assign DATA_OUT = mem_rdata;
    assign RD_VALID = !empty_q;
  end else begin : g_std
    logic [DATA_W-1:0] dout_q;
    logic              rvalid_q;

    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        dout_q   <= '0;
        rvalid_q <= 1'b0;
      end else if (SCLR) begin
        dout_q   <= '0;
        rvalid_q <= 1'b0;
      end else begin
        rvalid_q <= rd_acc;
        if (rd_acc) dout_q <= mem_rdata;
      end
    end

    assign DATA_OUT = dout_q;
    assign RD_VALID = rvalid_q;
  end

  assign EMPTY        = empty_q;
  assign FULL         = full_q;
  assign ALMOST_EMPTY = ae_q;
  assign ALMOST_FULL  = af_q;
  assign COUNT        = count_q;
  assign OVERFLOW     = ovf_q;
  assign UNDERFLOW    = unf_q;

endmodule : param_fifo

// File: tb/tb_param_fifo.sv
// -----------------------------------------------------------------------------
// tb_param_fifo
// Two instances: a standard-mode FIFO (DEPTH=16) and an FWFT FIFO (DEPTH=5).
// A queue-based reference model tracks contents and error flags; expected read
// data for the standard instance is pushed into a scoreboard queue when a read
// is issued and popped by a monitor whenever RD_VALID is seen.
// -----------------------------------------------------------------------------
module tb_param_fifo;

  localparam int S_DEPTH = 16;
  localparam int S_AF    = 14;
  localparam int S_AE    = 2;
  localparam int F_DEPTH = 5;
  localparam int F_AF    = 3;
  localparam int F_AE    = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Standard-mode instance signals.
  logic       s_sclr, s_wr, s_rd;
  logic [7:0] s_din, s_dout;
  logic       s_rv, s_empty, s_full, s_ae, s_af, s_ovf, s_unf;
  logic [4:0] s_count;

  // FWFT instance signals.
  logic       f_sclr, f_wr, f_rd;
  logic [7:0] f_din, f_dout;
  logic       f_rv, f_empty, f_full, f_ae, f_af, f_ovf, f_unf;
  logic [2:0] f_count;

  param_fifo #(
    .DATA_W(8), .DEPTH(S_DEPTH), .AF_THRESH(S_AF), .AE_THRESH(S_AE), .FWFT(0)
  ) u_std (
    .CLK(clk), .RST_N(rst_n), .SCLR(s_sclr), .DATA_IN(s_din),
    .WR_EN(s_wr), .RD_EN(s_rd), .DATA_OUT(s_dout), .RD_VALID(s_rv),
    .EMPTY(s_empty), .FULL(s_full), .ALMOST_EMPTY(s_ae), .ALMOST_FULL(s_af),
    .COUNT(s_count), .OVERFLOW(s_ovf), .UNDERFLOW(s_unf)
  );

  param_fifo #(
    .DATA_W(8), .DEPTH(F_DEPTH), .AF_THRESH(F_AF), .AE_THRESH(F_AE), .FWFT(1)
  ) u_fwft (
    .CLK(clk), .RST_N(rst_n), .SCLR(f_sclr), .DATA_IN(f_din),
    .WR_EN(f_wr), .RD_EN(f_rd), .DATA_OUT(f_dout), .RD_VALID(f_rv),
    .EMPTY(f_empty), .FULL(f_full), .ALMOST_EMPTY(f_ae), .ALMOST_FULL(f_af),
    .COUNT(f_count), .OVERFLOW(f_ovf), .UNDERFLOW(f_unf)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state.
  logic [7:0] q_s[$];    // standard FIFO contents
  logic [7:0] exp_s[$];  // scoreboard: read data owed by the standard FIFO
  logic       ovf_s = 1'b0, unf_s = 1'b0;
  logic [7:0] q_f[$];    // FWFT FIFO contents
  logic       ovf_f = 1'b0, unf_f = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_std_status();
    check("std_count", 32'(s_count), q_s.size());
    check("std_empty", 32'(s_empty), 32'(q_s.size() == 0));
    check("std_full",  32'(s_full),  32'(q_s.size() == S_DEPTH));
    check("std_ae",    32'(s_ae),    32'(q_s.size() <= S_AE));
    check("std_af",    32'(s_af),    32'(q_s.size() >= S_AF));
    check("std_ovf",   32'(s_ovf),   32'(ovf_s));
    check("std_unf",   32'(s_unf),   32'(unf_s));
  endtask

  task automatic check_fwft_status();
    check("fwft_count", 32'(f_count), q_f.size());
    check("fwft_empty", 32'(f_empty), 32'(q_f.size() == 0));
    check("fwft_full",  32'(f_full),  32'(q_f.size() == F_DEPTH));
    check("fwft_ae",    32'(f_ae),    32'(q_f.size() <= F_AE));
    check("fwft_af",    32'(f_af),    32'(q_f.size() >= F_AF));
    check("fwft_ovf",   32'(f_ovf),   32'(ovf_f));
    check("fwft_unf",   32'(f_unf),   32'(unf_f));
  endtask

  // One clock of stimulus on the standard instance; model updated from
  // pre-edge occupancy, status checked 1 time unit after the edge.
  task automatic cycle_std(input logic sclr, input logic wr, input logic rd, input logic [7:0] din);
    bit was_full, was_empty;
    s_sclr = sclr; s_wr = wr; s_rd = rd; s_din = din;
    @(posedge clk);
    was_full  = (q_s.size() == S_DEPTH);
    was_empty = (q_s.size() == 0);
    if (sclr) begin
      q_s.delete();
      ovf_s = 1'b0;
      unf_s = 1'b0;
    end else begin
      if (wr && was_full)  ovf_s = 1'b1;
      if (rd && was_empty) unf_s = 1'b1;
      if (rd && !was_empty) exp_s.push_back(q_s.pop_front());
      if (wr && !was_full)  q_s.push_back(din);
    end
    #1;
    s_sclr = 1'b0; s_wr = 1'b0; s_rd = 1'b0;
    check_std_status();
  endtask

  task automatic cycle_fwft(input logic wr, input logic rd, input logic [7:0] din);
    bit was_full, was_empty;
    f_wr = wr; f_rd = rd; f_din = din;
    @(posedge clk);
    was_full  = (q_f.size() == F_DEPTH);
    was_empty = (q_f.size() == 0);
    if (wr && was_full)  ovf_f = 1'b1;
    if (rd && was_empty) unf_f = 1'b1;
    if (rd && !was_empty) void'(q_f.pop_front());
    if (wr && !was_full)  q_f.push_back(din);
    #1;
    f_wr = 1'b0; f_rd = 1'b0;
    check_fwft_status();
  endtask

  // Monitors sample on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      check("std_rd_valid", 32'(s_rv), 32'(exp_s.size() != 0));
      if (s_rv && exp_s.size() != 0) check("std_dout", 32'(s_dout), 32'(exp_s.pop_front()));
      check("fwft_rd_valid", 32'(f_rv), 32'(q_f.size() != 0));
      if (f_rv && q_f.size() != 0) check("fwft_dout", 32'(f_dout), 32'(q_f[0]));
    end
  end

  initial begin
    s_sclr = 0; s_wr = 0; s_rd = 0; s_din = '0;
    f_sclr = 0; f_wr = 0; f_rd = 0; f_din = '0;

    #12 rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_std_dout", 32'(s_dout), 32'h0);
    check("rst_std_rv",   32'(s_rv),   32'h0);
    check_std_status();
    check_fwft_status();

    // Fill to full, then drain in order.
    for (int i = 1; i <= 16; i++) cycle_std(1'b0, 1'b1, 1'b0, 8'(i));
    for (int i = 0; i < 16; i++)  cycle_std(1'b0, 1'b0, 1'b1, 8'h00);

    // Overflow while full with a simultaneous accepted read.
    for (int i = 1; i <= 16; i++) cycle_std(1'b0, 1'b1, 1'b0, 8'(i));
    cycle_std(1'b0, 1'b1, 1'b1, 8'hAA);
    check("ovf_count15", 32'(s_count), 32'd15);
    for (int i = 0; i < 15; i++)  cycle_std(1'b0, 1'b0, 1'b1, 8'h00);

    // Underflow while empty with a simultaneous accepted write.
    cycle_std(1'b0, 1'b1, 1'b1, 8'h5A);
    check("unf_count1", 32'(s_count), 32'd1);
    cycle_std(1'b0, 1'b0, 1'b1, 8'h00);

    // Flush with a write pending: write ignored, flags back to reset values.
    for (int i = 0; i < 7; i++) cycle_std(1'b0, 1'b1, 1'b0, 8'($urandom));
    cycle_std(1'b1, 1'b1, 1'b0, 8'hC3);
    check("sclr_dout", 32'(s_dout), 32'h0);

    // Asynchronous reset asserted between edges mid-burst.
    cycle_std(1'b0, 1'b0, 1'b1, 8'h00);  // underflow, so a sticky flag is set
    for (int i = 0; i < 7; i++) cycle_std(1'b0, 1'b1, 1'b0, 8'($urandom));
    #2 rst_n = 1'b0;
    q_s.delete(); ovf_s = 1'b0; unf_s = 1'b0;
    q_f.delete(); ovf_f = 1'b0; unf_f = 1'b0;
    #1;
    check("arst_std_dout", 32'(s_dout), 32'h0);
    check("arst_std_rv",   32'(s_rv),   32'h0);
    check_std_status();
    check_fwft_status();
    @(negedge clk);
    rst_n = 1'b1;

    // FWFT, DEPTH=5: write-heavy then read-heavy random traffic.
    for (int i = 0; i < 60; i++) begin
      if (i < 30) cycle_fwft($urandom_range(0, 99) < 65, $urandom_range(0, 99) < 40, 8'($urandom));
      else        cycle_fwft($urandom_range(0, 99) < 40, $urandom_range(0, 99) < 65, 8'($urandom));
    end

    // Random mixed traffic on the standard instance.
    for (int i = 0; i < 80; i++)
      cycle_std(1'b0, $urandom_range(0, 99) < 55, $urandom_range(0, 99) < 45, 8'($urandom));

    cycle_std(1'b0, 1'b0, 1'b0, 8'h00);
    cycle_std(1'b0, 1'b0, 1'b0, 8'h00);
    check("std_scoreboard_drained", exp_s.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_param_fifo
